// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding and sizing constants for the sequential divider
package seq_divider_pkg;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done request and result bundle for the divider
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero, zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero, zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring-division iteration (shift in a dividend bit, trial subtract)
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic             dbit_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH:0]   acc_o,
    output logic             q_o
);
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   b_n;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] c;

    assign sh   = (acc_i << 1) | {{WIDTH{1'b0}}, dbit_i};
    assign b_n  = ~{1'b0, dsr_i};
    assign c[0] = 1'b1;

    for (genvar g = 0; g <= WIDTH; g++) begin : g_fa
        seq_divider_fa u_fa (
            .a_i(sh[g]),
            .b_i(b_n[g]),
            .c_i(c[g]),
            .s_o(trial[g]),
            .c_o(c[g+1])
        );
    end

    // No borrow out and a non-negative sign bit agree whenever acc < divisor.
    assign q_o   = c[WIDTH+1] & ~trial[WIDTH];
    assign acc_o = q_o ? trial : sh;
endmodule

// File: rtl/seq_divider_fa.sv
// seq_divider_fa: one-bit full adder cell
module seq_divider_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with start/busy/done handshake
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    seq_divider_if.slave  bus
);
    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d, step_acc;
    logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, q_shift;
    logic             dz_q, dz_d, zero_q, zero_d, step_q;

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .acc_i(acc_q),
        .dbit_i(dvd_q[WIDTH-1]),
        .dsr_i(dsr_q),
        .acc_o(step_acc),
        .q_o(step_q)
    );

    // The dividend register doubles as the quotient register as bits shift out.
    assign q_shift = {dvd_q[WIDTH-2:0], step_q};

    // Next state: accept requests in IDLE/DONE, iterate in DIV, publish results only at the end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        zero_d  = zero_q;
        case (state_q)
            DIV: begin
                acc_d = step_acc;
                dvd_d = q_shift;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_shift;
                    rem_d   = step_acc[WIDTH-1:0];
                    zero_d  = q_shift == '0;
                    dz_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.start && bus.divisor != '0) begin
                    state_d = DIV;
                    acc_d   = '0;
                    dvd_d   = bus.dividend;
                    dsr_d   = bus.divisor;
                    cnt_d   = CW'(WIDTH - 1);
                end else if (bus.start) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = bus.dividend;
                    dz_d    = 1'b1;
                    zero_d  = 1'b0;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any divide in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.busy      = state_q == DIV;
    assign bus.done      = state_q == DONE;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with directed and random divides
module tb_seq_divider;

    localparam int W = 8;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int z;
        int t0;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every Done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d: got quotient %0d, expected no Done", cyc, bus.quotient);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", int'(bus.quotient), mon_e.q);
                chk("remainder", int'(bus.remainder), mon_e.r);
                chk("div_zero", int'(bus.div_zero), mon_e.dz);
                chk("zero", int'(bus.zero), mon_e.z);
                chk("latency", cyc - mon_e.t0, mon_e.lat);
                chk("busy_at_done", int'(bus.busy), 0);
                if (mon_e.b != 0) begin
                    chk("invariant", int'(bus.quotient) * mon_e.b + int'(bus.remainder), mon_e.a);
                    chk("rem_lt_divisor", int'(int'(bus.remainder) < mon_e.b), 1);
                end
            end
        end
    end

    // Drive one request at the current negedge; push the expectation if it should be accepted.
    task automatic issue(input int a, input int b, input int q, input int r, input bit push);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a[W-1:0];
        bus.divisor  = b[W-1:0];
        if (push) begin
            e.a   = a;
            e.b   = b;
            e.q   = q;
            e.r   = r;
            e.dz  = int'(b == 0);
            e.z   = int'(q == 0);
            e.t0  = cyc;
            e.lat = (b != 0) ? W + 1 : 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout at cycle %0d: got no Done, expected Done within 40 cycles", cyc);
        end
    endtask

    initial begin
        int a, b;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_quotient", int'(bus.quotient), 0);
        chk("rst_remainder", int'(bus.remainder), 0);
        chk("rst_div_zero", int'(bus.div_zero), 0);
        chk("rst_zero", int'(bus.zero), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(200, 7, 28, 4, 1);
        repeat (8) begin
            chk("busy_in_div", int'(bus.busy), 1);
            chk("done_in_div", int'(bus.done), 0);
            @(negedge clk);
        end
        wait_done();
        @(negedge clk);

        issue(5, 0, 255, 5, 1);
        chk("dz_busy", int'(bus.busy), 0);
        wait_done();
        @(negedge clk);
        issue(3, 10, 0, 3, 1);
        wait_done();
        issue(255, 1, 255, 0, 1);
        wait_done();
        issue(0, 255, 0, 0, 1);
        wait_done();
        issue(255, 255, 1, 0, 1);
        wait_done();
        issue(254, 255, 0, 254, 1);
        wait_done();
        issue(128, 2, 64, 0, 1);
        wait_done();
        issue(0, 0, 255, 0, 1);
        wait_done();
        @(negedge clk);

        issue(100, 9, 11, 1, 1);
        repeat (2) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        issue(50, 5, 10, 0, 1);
        wait_done();
        @(negedge clk);

        issue(200, 7, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_quotient", int'(bus.quotient), 0);
        chk("abort_remainder", int'(bus.remainder), 0);
        repeat (15) @(negedge clk);
        issue(200, 7, 28, 4, 1);
        wait_done();

        repeat (150) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            issue(a, b, (b != 0) ? a / b : 255, (b != 0) ? a % b : a, 1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider for the datapath. It is the inverse arithmetic direction of the combinational add/subtract unit: one trial subtraction per clock, with quotient bits shifted in MSB first. It uses a start/busy/done handshake so the control FSM can issue a divide and wait for completion. It sits beside the adder in the ALU and reports the same style of status flags (Zero, plus a divide-by-zero error).

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
Start  input  1  request a divide; sampled only when Busy=0
Dividend  input  WIDTH  numerator; latched when Start is accepted
Divisor  input  WIDTH  denominator; latched when Start is accepted
Quotient  output  WIDTH  result quotient; held until the next accepted Start
Remainder  output  WIDTH  result remainder; held until the next accepted Start
Busy  output  1  high while an iteration is in progress
Done  output  1  single-cycle pulse when results become valid
DivZero  output  1  set with Done when Divisor==0; held with the results
Zero  output  1  Quotient==0; held with the results

Behaviour:
- Reset (synchronous, active-high, takes priority over all other inputs): state=IDLE; Quotient, Remainder, internal registers and iteration counter cleared; Busy=0, Done=0, DivZero=0, Zero=0.
- States: IDLE, DIV, DONE.
- IDLE, Start=1 at edge of cycle N:
  - Divisor!=0: latch operands; remainder acc (WIDTH+1 bits) = 0; counter = WIDTH-1; go to DIV. Busy=1 from cycle N+1.
  - Divisor==0: go directly to DONE with Quotient={WIDTH{1}}, Remainder=Dividend, DivZero=1, Zero=0. Done=1 in cycle N+1 only.
- DIV, each cycle:
  - acc' = {acc[WIDTH-1:0], dividend MSB}, then shift the dividend register left.
  - Trial = acc' - {0,Divisor}, computed at WIDTH+1 bits.
  - Trial non-negative (MSB=0): acc = trial, shift in quotient bit 1. Otherwise acc = acc', shift in quotient bit 0.
  - Counter decrements each cycle. At counter==0, the final results are written to Quotient and Remainder, Zero is updated, DivZero=0, and the state goes to DONE.
- Latency: Start sampled in cycle N, WIDTH DIV cycles (N+1..N+WIDTH), Done=1 and Busy=0 in cycle N+WIDTH+1 (N+9 at the default WIDTH).
- DONE lasts exactly one cycle, then returns to IDLE. Start=1 during DONE is accepted exactly as in IDLE, so back-to-back divides are allowed.
- Start while in DIV (Busy=1) is ignored. The operands in flight are unaffected.
- Quotient, Remainder, DivZero and Zero change only on result write or reset. They must not show intermediate iteration values.
- Reset during DIV: abort immediately, take reset values, and assert no Done pulse.
- Invariant for Divisor!=0: Dividend == Quotient*Divisor + Remainder, with Remainder < Divisor.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DIV, DONE);
  - the default WIDTH constant;
  - a counter-width constant of $clog2(WIDTH).
- Sub-module div_step: combinational single iteration. Inputs are the acc, the next dividend bit and the divisor. Outputs are the next acc and the quotient bit. Internally it uses a WIDTH+1 subtract built from the team's full-adder cell with the B input inverted and carry-in=1.
- The top level holds the FSM, counter and registers.

Test Plan:
- Dividend=200, Divisor=7, Start pulsed in cycle 0 -> Busy=1 in cycles 1-8; Done=1 in cycle 9 with Quotient=28, Remainder=4, Zero=0, DivZero=0.
- Dividend=5, Divisor=0 -> Done=1 in cycle 1, Busy never high; Quotient=8'hFF, Remainder=5, DivZero=1.
- Dividend=3, Divisor=10 -> Quotient=0, Remainder=3, Zero=1; Dividend=255, Divisor=1 -> Quotient=255, Remainder=0, Zero=0.
- Start a 100/9 divide, pulse Start with 50/5 in cycle 4 -> second request ignored; Done in cycle 9 with Quotient=11, Remainder=1. Then Start 50/5 during the Done cycle -> accepted; Done 9 cycles later with Quotient=10, Remainder=0.
- Start a 200/7 divide, assert Reset in cycle 4 -> from cycle 5 Busy=0, Done=0, Quotient=0, Remainder=0, no Done pulse follows. A subsequent 200/7 divide completes normally.
- Random sweep of all Dividend/Divisor pairs at WIDTH=8 -> every result satisfies the invariant and Done latency is exactly 9 cycles, or 1 cycle for Divisor=0.
